// File: rtl/gate_state_mac.sv
// gate_state_mac: streaming complex gate x state-vector multiplier, one complex MAC per accepted gate beat.
// Build option: define GSM_ROUND_EN for round-half-up results; otherwise results truncate toward -inf.
module gate_state_mac #(
    parameter int NQ    = 2,
    parameter int WIDTH = 8,
    parameter int FRAC  = 6,
    localparam int DIM  = 2 ** NQ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic        [DIM*WIDTH-1:0]   state_re,
    input  logic        [DIM*WIDTH-1:0]   state_im,
    input  logic                          gate_valid,
    output logic                          gate_ready,
    input  logic signed [WIDTH-1:0]       gate_re,
    input  logic signed [WIDTH-1:0]       gate_im,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH-1:0]       out_re,
    output logic signed [WIDTH-1:0]       out_im,
    output logic        [NQ-1:0]          out_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag
);
    localparam int PW   = 2 * WIDTH;
    localparam int ACCW = 2 * WIDTH + NQ + 1;
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - ACCW'(1);

    // state | meaning
    // IDLE  | waiting for start; gate beats ignored
    // RUN   | accepting gate beats, one MAC per beat
    // DRAIN | last row result waiting for its output handshake
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

    fsm_t                    state_q, state_d;
    logic signed [WIDTH-1:0] st_re_q [DIM];
    logic signed [WIDTH-1:0] st_im_q [DIM];
    logic        [NQ-1:0]    row_q, col_q;
    logic signed [ACCW-1:0]  acc_re_q, acc_im_q;
    logic                    out_valid_q, done_q, sat_q;
    logic signed [WIDTH-1:0] out_re_q, out_im_q;
    logic        [NQ-1:0]    out_idx_q;

    logic                    beat, last_col, last_row, out_hs;
    logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
    logic signed [ACCW-1:0]  sum_re, sum_im;
    logic        [WIDTH:0]   res_re, res_im;

    // Returns {saturated, value} for one accumulated component.
    function automatic logic [WIDTH:0] scale_sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] r;
        r = a;
`ifdef GSM_ROUND_EN
        r = r + (ACCW'(1) <<< (FRAC - 1));
`endif
        r = r >>> FRAC;
        if (r > SAT_MAX) begin
            return {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (r < SAT_MIN) begin
            return {1'b1, SAT_MIN[WIDTH-1:0]};
        end
        return {1'b0, r[WIDTH-1:0]};
    endfunction

    assign beat     = gate_valid && gate_ready;
    assign last_col = (col_q == NQ'(DIM - 1));
    assign last_row = (row_q == NQ'(DIM - 1));
    assign out_hs   = out_valid_q && out_ready;

    assign p_rr   = PW'(gate_re) * PW'(st_re_q[col_q]);
    assign p_ii   = PW'(gate_im) * PW'(st_im_q[col_q]);
    assign p_ri   = PW'(gate_re) * PW'(st_im_q[col_q]);
    assign p_ir   = PW'(gate_im) * PW'(st_re_q[col_q]);
    assign sum_re = acc_re_q + ACCW'(p_rr) - ACCW'(p_ii);
    assign sum_im = acc_im_q + ACCW'(p_ri) + ACCW'(p_ir);
    assign res_re = scale_sat(sum_re);
    assign res_im = scale_sat(sum_im);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (beat && last_col && last_row) state_d = DRAIN;
            DRAIN:   if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gate_ready = (state_q == RUN) && !(out_valid_q && !out_ready);
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DIM; k++) begin
                st_re_q[k] <= '0;
                st_im_q[k] <= '0;
            end
            row_q       <= '0;
            col_q       <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && out_hs;
            if (state_q == IDLE && start) begin
                for (int k = 0; k < DIM; k++) begin
                    st_re_q[k] <= state_re[k*WIDTH +: WIDTH];
                    st_im_q[k] <= state_im[k*WIDTH +: WIDTH];
                end
                row_q    <= '0;
                col_q    <= '0;
                acc_re_q <= '0;
                acc_im_q <= '0;
                sat_q    <= 1'b0;
            end else if (beat) begin
                if (last_col) begin
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                    col_q    <= '0;
                    row_q    <= row_q + NQ'(1);
                end else begin
                    acc_re_q <= sum_re;
                    acc_im_q <= sum_im;
                    col_q    <= col_q + NQ'(1);
                end
            end
            // A completed row may overwrite a result handshaken in the same cycle.
            if (beat && last_col) begin
                out_valid_q <= 1'b1;
                out_re_q    <= res_re[WIDTH-1:0];
                out_im_q    <= res_im[WIDTH-1:0];
                out_idx_q   <= row_q;
                if (res_re[WIDTH] || res_im[WIDTH]) sat_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_gate_state_mac.sv
// Bench for gate_state_mac: an NQ=1 instance for the directed vectors and an NQ=2 instance for random jobs.
// Results are compared against a plain-arithmetic complex matrix-vector model.
module tb_gate_state_mac;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        gate_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] st_re = '0, st_im = '0;
    logic [7:0]  gate_re = '0, gate_im = '0;

    logic       gr1, ov1, busy1, done1, sat1;
    logic [7:0] ore1, oim1;
    logic [0:0] idx1;
    logic       gr2, ov2, busy2, done2, sat2;
    logic [7:0] ore2, oim2;
    logic [1:0] idx2;

    logic       o_gr, o_ov, o_busy, o_done, o_sat;
    logic [7:0] o_re, o_im;
    logic [1:0] o_idx;

    int checks = 0;
    int errors = 0;

    int m_gre [16], m_gim [16], m_sre [4], m_sim [4];
    int x_re [4], x_im [4], got_re [4], got_im [4];
    bit x_sat;

    always #5 clk = ~clk;

    gate_state_mac #(.NQ(1), .WIDTH(8), .FRAC(6)) u_dut1 (
        .clk(clk), .reset(reset), .start(start && !sel),
        .state_re(st_re[15:0]), .state_im(st_im[15:0]),
        .gate_valid(gate_valid && !sel), .gate_ready(gr1),
        .gate_re(gate_re), .gate_im(gate_im),
        .out_valid(ov1), .out_ready(out_ready || sel),
        .out_re(ore1), .out_im(oim1), .out_idx(idx1),
        .busy(busy1), .done(done1), .sat_flag(sat1)
    );

    gate_state_mac #(.NQ(2), .WIDTH(8), .FRAC(6)) u_dut2 (
        .clk(clk), .reset(reset), .start(start && sel),
        .state_re(st_re), .state_im(st_im),
        .gate_valid(gate_valid && sel), .gate_ready(gr2),
        .gate_re(gate_re), .gate_im(gate_im),
        .out_valid(ov2), .out_ready(out_ready || !sel),
        .out_re(ore2), .out_im(oim2), .out_idx(idx2),
        .busy(busy2), .done(done2), .sat_flag(sat2)
    );

    always_comb begin
        o_gr = gr1; o_ov = ov1; o_busy = busy1; o_done = done1; o_sat = sat1;
        o_re = ore1; o_im = oim1; o_idx = {1'b0, idx1};
        if (sel) begin
            o_gr = gr2; o_ov = ov2; o_busy = busy2; o_done = done2; o_sat = sat2;
            o_re = ore2; o_im = oim2; o_idx = idx2;
        end
    end

    typedef struct packed {
        logic [3:0][7:0] g_re;   // element index = row*2+col, highest index leftmost
        logic [3:0][7:0] g_im;
        logic [1:0][7:0] s_re;
        logic [1:0][7:0] s_im;
        logic [1:0][7:0] e_re;
        logic [1:0][7:0] e_im;
        logic            e_sat;
    } vec_t;

    vec_t vecs [4];

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model(input int dim);
        longint are, aim, qre, qim;
        x_sat = 1'b0;
        for (int r = 0; r < dim; r++) begin
            are = 0;
            aim = 0;
            for (int c = 0; c < dim; c++) begin
                are += longint'(m_gre[r*dim+c]) * m_sre[c] - longint'(m_gim[r*dim+c]) * m_sim[c];
                aim += longint'(m_gre[r*dim+c]) * m_sim[c] + longint'(m_gim[r*dim+c]) * m_sre[c];
            end
`ifdef GSM_ROUND_EN
            are += 32;
            aim += 32;
`endif
            qre = are >>> 6;
            qim = aim >>> 6;
            if (qre > 127 || qre < -128 || qim > 127 || qim < -128) x_sat = 1'b1;
            x_re[r] = int'(qre > 127 ? 127 : (qre < -128 ? -128 : qre));
            x_im[r] = int'(qim > 127 ? 127 : (qim < -128 ? -128 : qim));
        end
    endtask

    task automatic randomize_job(input int dim);
        for (int k = 0; k < dim*dim; k++) begin
            m_gre[k] = int'($urandom_range(0, 255)) - 128;
            m_gim[k] = int'($urandom_range(0, 255)) - 128;
        end
        for (int k = 0; k < 4; k++) begin
            m_sre[k] = int'($urandom_range(0, 255)) - 128;
            m_sim[k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // vmode 0: gate_valid held high; 1: random valid, random start pulses, noisy state inputs.
    // rmode 0: always ready; 1: random ready; 2: ready low for 10 cycles after first result.
    task automatic run_job(input int dim, input int vmode, input int rmode, input int abort_after);
        int n, beat, nout, cyc, post, done_cnt, stall, last_hs;
        bit stall_used, gr_drop, hold_ok;
        logic [7:0] hold_re, hold_im;
        n = dim * dim;
        model(dim);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            st_re[k*8 +: 8] = 8'(m_sre[k]);
            st_im[k*8 +: 8] = 8'(m_sim[k]);
        end
        start = 1'b1;
        gate_valid = 1'b1;
        gate_re = 8'(m_gre[0]);
        gate_im = 8'(m_gim[0]);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        chk("sat_clear_on_start", o_sat, 0);
        beat = 0; nout = 0; cyc = 0; post = 0; done_cnt = 0; stall = 0; last_hs = -10;
        stall_used = 1'b0; gr_drop = 1'b0; hold_ok = 1'b1; hold_re = '0; hold_im = '0;
        while (post < 3 && cyc < 400) begin
            if (vmode == 1) begin
                st_re = $urandom();
                st_im = $urandom();
                start = (nout < dim) && ($urandom_range(0, 7) == 0);
            end
            gate_valid = (beat < n) && (vmode == 0 || $urandom_range(0, 2) != 0);
            if (beat < n) begin
                gate_re = 8'(m_gre[beat]);
                gate_im = 8'(m_gim[beat]);
            end
            if (rmode == 2 && !stall_used && o_ov) begin
                stall = 10; stall_used = 1'b1; hold_re = o_re; hold_im = o_im;
            end
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
            else begin
                out_ready = (stall == 0);
                if (stall > 0) stall--;
            end
            #1;
            if (rmode == 2 && stall_used && !out_ready && (!o_ov || o_re != hold_re || o_im != hold_im))
                hold_ok = 1'b0;
            if (!out_ready && gate_valid && !o_gr) gr_drop = 1'b1;
            if (o_done) begin
                done_cnt++;
                chk("done_timing", cyc, last_hs + 1);
            end
            if (o_ov && out_ready) begin
                if (nout < dim) begin
                    chk("out_idx", o_idx, nout);
                    chk("out_re", s8(o_re), x_re[nout]);
                    chk("out_im", s8(o_im), x_im[nout]);
                    got_re[nout] = s8(o_re);
                    got_im[nout] = s8(o_im);
                end else begin
                    chk("extra_result", nout + 1, dim);
                end
                nout++;
                last_hs = cyc;
            end
            if (gate_valid && o_gr) beat++;
            @(posedge clk);
            if (abort_after > 0 && beat >= abort_after) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_gate_ready", o_gr, 0);
                chk("abort_out_valid", o_ov, 0);
                chk("abort_busy", o_busy, 0);
                chk("abort_done", o_done, 0);
                chk("abort_sat", o_sat, 0);
                chk("abort_out_re", o_re, 0);
                chk("abort_out_im", o_im, 0);
                chk("abort_out_idx", o_idx, 0);
                @(negedge clk);
                start = 1'b0; gate_valid = 1'b0; out_ready = 1'b1;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
            if (nout >= dim) post++;
        end
        start = 1'b0;
        gate_valid = 1'b0;
        out_ready = 1'b1;
        chk("results_count", nout, dim);
        chk("done_once", done_cnt, 1);
        chk("busy_end", o_busy, 0);
        chk("sat_flag", o_sat, x_sat);
        if (rmode == 2) begin
            chk("stall_seen", stall_used, 1);
            chk("stall_hold", hold_ok, 1);
            chk("gate_ready_drop", gr_drop, 1);
        end
    endtask

    initial begin
        vecs[0] = '{g_re: {8'd64, 8'd0, 8'd0, 8'd64}, g_im: '0,
                    s_re: {8'd0, 8'd64}, s_im: {8'd64, 8'd0},
                    e_re: {8'd0, 8'd64}, e_im: {8'd64, 8'd0}, e_sat: 1'b0};
        vecs[1] = '{g_re: {8'hD3, 8'd45, 8'd45, 8'd45}, g_im: '0,
                    s_re: {8'd0, 8'd64}, s_im: '0,
                    e_re: {8'd45, 8'd45}, e_im: '0, e_sat: 1'b0};
        vecs[2] = '{g_re: {8'd127, 8'd127, 8'd127, 8'd127}, g_im: '0,
                    s_re: {8'd127, 8'd127}, s_im: '0,
                    e_re: {8'd127, 8'd127}, e_im: '0, e_sat: 1'b1};
`ifdef GSM_ROUND_EN
        vecs[3] = '{g_re: {8'd32, 8'd0, 8'd0, 8'd32}, g_im: '0,
                    s_re: {8'hFF, 8'd1}, s_im: '0,
                    e_re: {8'd0, 8'd1}, e_im: '0, e_sat: 1'b0};
`else
        vecs[3] = '{g_re: {8'd32, 8'd0, 8'd0, 8'd32}, g_im: '0,
                    s_re: {8'hFF, 8'd1}, s_im: '0,
                    e_re: {8'hFF, 8'd0}, e_im: '0, e_sat: 1'b0};
`endif

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_gate_ready", o_gr, 0);
            chk("rst_out_valid", o_ov, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_sat", o_sat, 0);
            chk("rst_out_re", o_re, 0);
            chk("rst_out_im", o_im, 0);
            chk("rst_out_idx", o_idx, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        sel = 1'b1;
        gate_valid = 1'b1;
        gate_re = 8'h40;
        repeat (3) @(negedge clk);
        chk("idle_beat_busy", o_busy, 0);
        chk("idle_beat_out_valid", o_ov, 0);
        chk("idle_beat_gate_ready", o_gr, 0);
        gate_valid = 1'b0;

        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                m_gre[k] = s8(vecs[i].g_re[k]);
                m_gim[k] = s8(vecs[i].g_im[k]);
            end
            for (int k = 0; k < 4; k++) begin
                m_sre[k] = (k < 2) ? s8(vecs[i].s_re[k[0]]) : 0;
                m_sim[k] = (k < 2) ? s8(vecs[i].s_im[k[0]]) : 0;
            end
            run_job(2, 0, 0, 0);
            for (int r = 0; r < 2; r++) begin
                chk("tbl_re", got_re[r], s8(vecs[i].e_re[r]));
                chk("tbl_im", got_im[r], s8(vecs[i].e_im[r]));
            end
            chk("tbl_sat", o_sat, vecs[i].e_sat);
            if (vecs[i].e_sat) begin
                repeat (5) @(negedge clk);
                chk("sat_sticky", o_sat, 1);
            end
        end

        randomize_job(2);
        run_job(2, 0, 2, 0);

        sel = 1'b1;
        for (int j = 0; j < 6; j++) begin
            randomize_job(4);
            run_job(4, 1, 1, 0);
        end
        randomize_job(4);
        run_job(4, 0, 2, 0);

        randomize_job(4);
        run_job(4, 1, 1, 6);
        randomize_job(4);
        run_job(4, 1, 1, 0);
        randomize_job(4);
        run_job(4, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
